pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the MIPS datapath. It replaces the fixed 32-bit PC register and branch mux with one registered unit. The unit computes PC+4, branch, jump, jump-register, exception and exception-return targets. It also handles pipeline stall, flags misaligned targets and sequences boot after reset. It sits between the control unit/ALU and the instruction memory address port.

---
 rtl/pc_sequencer.sv | 135 +++++++++++++
 tb/tb_pc_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: registered fetch address with boot, branch,
// jump, jump-register, exception/eret redirects, stall and misalign trap.
//
// Ports:
//   Clk, Reset (async active-low)
//   Stall, Branch, BranchNe, Zero, Jump, JumpReg, Eret, Exception
//   Imm, JumpIndex, RegTarget           -- target operands
//   PresentState, PCPlus4, Valid, Taken -- fetch address and selection
//   AddrErr, EPC                        -- trap status
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter int               IMM_WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [31:0]      EXC_VECTOR   = 32'h0000_0180
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Stall,
  input  logic                 Branch,
  input  logic                 BranchNe,
  input  logic                 Zero,
  input  logic                 Jump,
  input  logic                 JumpReg,
  input  logic                 Eret,
  input  logic                 Exception,
  input  logic [IMM_WIDTH-1:0] Imm,
  input  logic [25:0]          JumpIndex,
  input  logic [WIDTH-1:0]     RegTarget,
  output logic [WIDTH-1:0]     PresentState,
  output logic [WIDTH-1:0]     PCPlus4,
  output logic                 Valid,
  output logic                 Taken,
  output logic                 AddrErr,
  output logic [WIDTH-1:0]     EPC
);

  localparam logic [WIDTH-1:0] EXC = WIDTH'(EXC_VECTOR);

  typedef enum logic {
    BOOT,
    RUN
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] pc, pc_n;
  logic [WIDTH-1:0] epc, epc_n;
  logic             ae, ae_n;

  logic [WIDTH-1:0] imm_x;
  logic [WIDTH-1:0] br_tgt;
  logic [WIDTH-1:0] j_tgt;
  logic [WIDTH-1:0] cand;
  logic             chk;
  logic             br_taken;
  logic             mis;

  assign PCPlus4  = pc + WIDTH'(4);
  assign imm_x    = {{(WIDTH-IMM_WIDTH){Imm[IMM_WIDTH-1]}}, Imm};
  assign br_tgt   = PCPlus4 + {imm_x[WIDTH-3:0], 2'b00};
  assign j_tgt    = {PCPlus4[WIDTH-1:28], JumpIndex, 2'b00};
  assign br_taken = Branch & (BranchNe ? ~Zero : Zero);

  // Candidate redirect; only register/EPC targets can be misaligned.
  always_comb begin
    cand = PCPlus4;
    chk  = 1'b0;
    priority case (1'b1)
      Eret: begin
        cand = epc;
        chk  = 1'b1;
      end
      JumpReg: begin
        cand = RegTarget;
        chk  = 1'b1;
      end
      Jump:     cand = j_tgt;
      br_taken: cand = br_tgt;
      default:  cand = PCPlus4;
    endcase
  end

  assign mis = chk & (|cand[1:0]);

  // Next-state and outputs.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    epc_n   = epc;
    ae_n    = ae;
    Valid   = 1'b0;
    Taken   = 1'b0;
    unique case (state)
      BOOT: begin
        state_n = RUN;
      end
      RUN: begin
        Valid = 1'b1;
        Taken = Exception | Eret | JumpReg | Jump | br_taken;
        if (Exception) begin
          pc_n  = EXC;
          epc_n = pc;
          ae_n  = 1'b0;
        end else if (mis) begin
          // traps even under stall
          pc_n  = EXC;
          epc_n = pc;
          ae_n  = 1'b1;
        end else if (!Stall) begin
          pc_n = cand;
          ae_n = 1'b0;
        end
      end
      default: state_n = BOOT;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= BOOT;
      pc    <= RESET_VECTOR;
      epc   <= '0;
      ae    <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      epc   <= epc_n;
      ae    <= ae_n;
    end
  end

  assign PresentState = pc;
  assign EPC          = epc;
  assign AddrErr      = ae;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed plan then random traffic,
// checked against a behavioural next-PC model.
module tb_pc_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Stall = 1'b0;
  logic        Branch = 1'b0;
  logic        BranchNe = 1'b0;
  logic        Zero = 1'b0;
  logic        Jump = 1'b0;
  logic        JumpReg = 1'b0;
  logic        Eret = 1'b0;
  logic        Exception = 1'b0;
  logic [15:0] Imm = '0;
  logic [25:0] JumpIndex = '0;
  logic [31:0] RegTarget = '0;
  logic [31:0] PresentState;
  logic [31:0] PCPlus4;
  logic        Valid;
  logic        Taken;
  logic        AddrErr;
  logic [31:0] EPC;

  pc_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall),
    .Branch(Branch), .BranchNe(BranchNe), .Zero(Zero),
    .Jump(Jump), .JumpReg(JumpReg), .Eret(Eret),
    .Exception(Exception), .Imm(Imm), .JumpIndex(JumpIndex),
    .RegTarget(RegTarget), .PresentState(PresentState),
    .PCPlus4(PCPlus4), .Valid(Valid), .Taken(Taken),
    .AddrErr(AddrErr), .EPC(EPC)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] epc;
    logic        valid;
    logic        ae;
    logic        taken;
    string       tag;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // model state
  bit          m_run = 0;
  logic [31:0] m_pc  = 32'h0;
  logic [31:0] m_epc = 32'h0;
  bit          m_ae  = 0;

  task automatic check(input string name, input string tag,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %h want %h at %0t",
               tag, name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("pc", e.tag, PresentState, e.pc);
      check("pc4", e.tag, PCPlus4, e.pc4);
      check("epc", e.tag, EPC, e.epc);
      check("valid", e.tag, 32'(Valid), 32'(e.valid));
      check("addrerr", e.tag, 32'(AddrErr), 32'(e.ae));
      check("taken", e.tag, 32'(Taken), 32'(e.taken));
    end
  end

  function automatic exp_t snap(input string tag, input bit tk);
    exp_t e;
    e.pc    = m_pc;
    e.pc4   = m_pc + 32'd4;
    e.epc   = m_epc;
    e.valid = m_run;
    e.ae    = m_ae;
    e.taken = tk;
    e.tag   = tag;
    return e;
  endfunction

  task automatic model_reset();
    m_run = 0;
    m_pc  = 32'h0;
    m_epc = 32'h0;
    m_ae  = 0;
  endtask

  task automatic hold_reset(input int n);
    Reset = 1'b0;
    model_reset();
    repeat (n) begin
      q.push_back(snap("reset", 0));
      @(posedge Clk);
      #1;
    end
  endtask

  // Called at posedge+1; applies inputs for one cycle.
  task automatic drive(input string tag, input bit st, input bit br,
                       input bit bne, input bit z, input bit j,
                       input bit jr, input bit er, input bit ex,
                       input logic [15:0] imm, input logic [25:0] ji,
                       input logic [31:0] rt);
    logic [31:0] pc4, tgt;
    bit btk, tk, reg_tgt;
    Reset = 1'b1;
    Stall = st; Branch = br; BranchNe = bne; Zero = z;
    Jump = j; JumpReg = jr; Eret = er; Exception = ex;
    Imm = imm; JumpIndex = ji; RegTarget = rt;
    pc4 = m_pc + 32'd4;
    btk = br && (bne ? !z : z);
    tk  = m_run && (ex || er || jr || j || btk);
    q.push_back(snap(tag, tk));
    if (!m_run) begin
      m_run = 1;
    end else if (ex) begin
      m_epc = m_pc; m_pc = 32'h180; m_ae = 0;
    end else begin
      reg_tgt = er || jr;
      if (er)       tgt = m_epc;
      else if (jr)  tgt = rt;
      else if (j)   tgt = {pc4[31:28], ji, 2'b00};
      else if (btk) tgt = pc4 + 32'($signed(imm)) * 32'd4;
      else          tgt = pc4;
      if (reg_tgt && (tgt % 4 != 0)) begin
        m_epc = m_pc; m_pc = 32'h180; m_ae = 1;
      end else if (!st) begin
        m_pc = tgt; m_ae = 0;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input string tag);
    drive(tag, 0, 0, 0, 0, 0, 0, 0, 0, '0, '0, '0);
  endtask

  task automatic go(input logic [31:0] a);
    drive("jr", 0, 0, 0, 0, 0, 1, 0, 0, '0, '0, a);
  endtask

  task automatic async_reset();
    #1;
    Reset = 1'b0;
    model_reset();
    q.push_back(snap("async_rst", 0));
    @(posedge Clk);
    #1;
  endtask

  initial begin
    @(posedge Clk);
    #1;
    hold_reset(3);
    // boot: PC 0,0,4,8 ; Valid 0,1,1,1 (first reset sample already queued)
    idle("boot0");
    idle("boot1");
    idle("boot2");
    // branch taken backwards
    go(32'h10);
    drive("beq", 0, 1, 0, 1, 0, 0, 0, 0, 16'hFFFE, '0, '0);
    idle("beq_dst");
    // bne with Zero=1 not taken
    go(32'h10);
    drive("bne", 0, 1, 1, 1, 0, 0, 0, 0, 16'hFFFE, '0, '0);
    idle("bne_dst");
    // jump and jump register
    go(32'h1000_0000);
    drive("j", 0, 0, 0, 0, 1, 0, 0, 0, '0, 26'h40, '0);
    go(32'h2000);
    idle("jr_dst");
    // stall, exception during stall, eret
    go(32'h40);
    repeat (3)
      drive("stall", 1, 0, 0, 0, 0, 0, 0, 0, '0, '0, '0);
    drive("exc_st", 1, 0, 0, 0, 0, 0, 0, 1, '0, '0, '0);
    drive("eret", 0, 0, 0, 0, 0, 0, 1, 0, '0, '0, '0);
    // exception + eret together
    drive("exc_eret", 0, 0, 0, 0, 0, 0, 1, 1, '0, '0, '0);
    idle("exc_eret_dst");
    // misaligned jr
    go(32'h80);
    go(32'h2002);
    idle("ae_clear");
    idle("ae_done");
    // jump beats branch
    drive("j_br", 0, 1, 0, 1, 1, 0, 0, 0, 16'h0010, 26'h123, '0);
    // misaligned jr under stall still traps
    drive("mis_st", 1, 0, 0, 0, 0, 1, 0, 0, '0, '0, 32'h3001);
    // wrap
    go(32'hFFFF_FFFC);
    idle("wrap");
    idle("wrap2");
    async_reset();
    idle("reboot0");
    idle("reboot1");
    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rt;
      rt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) rt[1:0] = 2'($urandom_range(1, 3));
      drive("rand",
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 1) == 0,
            $urandom_range(0, 1) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 15) == 0,
            16'($urandom), 26'($urandom), rt);
      if (i == 200) async_reset();
    end
    idle("tail");
    @(negedge Clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d entries want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
